issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Instruction buffer and dual-issue pairing controller between fetch and the two decoder/execute lanes of the core.
- Accepts fetch packets of up to two instructions into an in-order FIFO.
- Each cycle it presents one or two head instructions to the issue slots.
- Slot 1 is paired with slot 0 only when the two have no register dependency and slot 0 does not end the bundle.

Parameters:
- DEPTH, 8, instruction buffer entries (power of two, >= 4); each entry holds a 32-bit instruction and a 32-bit PC.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- fetch_valid_i  in  1  fetch packet valid.
- fetch_mask_i  in  2  per-slot valid within the packet (bit0 = slot 0).
- fetch_instr0_i  in  32  packet instruction 0.
- fetch_instr1_i  in  32  packet instruction 1.
- fetch_pc_i  in  32  PC of instruction 0; instruction 1 PC = fetch_pc_i + 4.
- fetch_ready_o  out  1  buffer can take a full packet.
- issue_valid_o  out  2  bit0 = slot 0 valid, bit1 = slot 1 valid.
- issue_instr0_o  out  32  slot 0 instruction.
- issue_pc0_o  out  32  slot 0 PC.
- issue_instr1_o  out  32  slot 1 instruction.
- issue_pc1_o  out  32  slot 1 PC.
- issue_ready_i  in  1  downstream accepts the presented bundle (all valid slots together).
- flush_i  in  1  discard all buffered instructions (redirect/mispredict).

Behaviour:
- State: read pointer, write pointer (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits), entry array.
- Reset (async, rst_ni low): pointers and count = 0; fetch_ready_o = 1; issue_valid_o = 2'b00. Entry contents are don't-care.
- fetch_ready_o = (count <= DEPTH-2). This is computed from the current count, not the post-pop count.
- Push occurs when fetch_valid_i & fetch_ready_o & !flush_i.
  - Slots are written in order: slot 0 first if mask[0], then slot 1 if mask[1], into consecutive entries.
  - Pushed entries = popcount(mask). Mask 2'b00 pushes nothing. Mask 2'b10 pushes only instruction 1, with PC fetch_pc_i+4.
  - fetch_valid_i while fetch_ready_o = 0 is ignored; fetch must hold the packet.
- Latency: a pushed instruction is visible at the issue outputs the cycle after the push; there is no same-cycle bypass.
- Issue outputs are combinational from the head entries (head and head+1, wrapped).
  - issue_valid_o[0] = (count >= 1).
  - issue_valid_o[1] = (count >= 2) & pair_ok.
  - When a slot is invalid, its instruction and PC outputs still show the entry contents; they are don't-care.
- Decode for pairing uses opcode = instr[6:0], with the core's opcode set:
  - Writes rd: ALUI, ALUR, LUI, AUIPC, JAL, JALR.
  - Reads rs1 (instr[19:15]): ALUI, ALUR, JALR, BRANCH.
  - Reads rs2 (instr[24:20]): ALUR, BRANCH.
  - Control flow: JAL, JALR, BRANCH.
  - Any other opcode: no reads, no write, not control flow; it still occupies a slot.
- pair_ok = 0 if any of the following holds:
  - slot 0 is control flow;
  - slot 0 writes rd0 != 0 and slot 1 reads rs1 == rd0 or rs2 == rd0 (RAW);
  - both write, rd0 == rd1 and rd0 != 0 (WAW).
  Otherwise pair_ok = 1. Register x0 never creates a dependency.
- Pop occurs when issue_ready_i & issue_valid_o[0] & !flush_i. Pop count = popcount(issue_valid_o); the read pointer advances by that count with wrap.
- Simultaneous push and pop: count_next = count + pushed - popped.
- Flush: synchronous, highest priority. Pointers and count go to 0 next cycle, and a push or pop in the same cycle is suppressed. issue_valid_o is 0 the cycle after the flush.
- Reset asserted mid-operation clears state immediately, regardless of clock.
- Count never exceeds DEPTH. Overflow and underflow are impossible by construction; the bench asserts this.

Test Plan:
- Reset then push packet mask=11, instr0 = addi x1,x0,5, instr1 = addi x2,x0,7, pc=0x100. Required: next cycle issue_valid_o=11, pc0=0x100, pc1=0x104. With issue_ready_i=1, count returns to 0.
- RAW: instr0 = addi x3,x0,1; instr1 = add x4,x3,x3. Required: issue_valid_o=01 first. After the pop, x4's add issues alone in slot 0 with issue_valid_o=01.
- x0 and control flow: instr0 = addi x0,x0,0; instr1 = add x5,x0,x0 → issue_valid_o=11. instr0 = beq; instr1 = addi → issue_valid_o=01.
- Full/wrap: DEPTH=8, issue_ready_i=0, push four mask=11 packets. Required: fetch_ready_o=0 at count=8 (already 0 at 7). Then drain and refill across the wrap; FIFO order and PCs are preserved.
- Mask 2'b10 with pc=0x200 → single entry with PC 0x204. Simultaneous push (2) and pop (2) at count=4 keeps count=4.
- Flush asserted together with fetch_valid_i and issue_ready_i at count=5. Required: count=0 next cycle, nothing pushed, issue_valid_o=00. Reset asserted mid-stream clears count asynchronously.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - fetch and issue handshake bundle for the issue scheduler
interface issue_scheduler_if;
    logic        fetch_valid_i;
    logic [1:0]  fetch_mask_i;
    logic [31:0] fetch_instr0_i;
    logic [31:0] fetch_instr1_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic [1:0]  issue_valid_o;
    logic [31:0] issue_instr0_o;
    logic [31:0] issue_pc0_o;
    logic [31:0] issue_instr1_o;
    logic [31:0] issue_pc1_o;
    logic        issue_ready_i;

    modport slave (
        input  fetch_valid_i, fetch_mask_i, fetch_instr0_i, fetch_instr1_i, fetch_pc_i,
        input  issue_ready_i,
        output fetch_ready_o, issue_valid_o, issue_instr0_o, issue_pc0_o,
        output issue_instr1_o, issue_pc1_o
    );

    modport master (
        output fetch_valid_i, fetch_mask_i, fetch_instr0_i, fetch_instr1_i, fetch_pc_i,
        output issue_ready_i,
        input  fetch_ready_o, issue_valid_o, issue_instr0_o, issue_pc0_o,
        input  issue_instr1_o, issue_pc1_o
    );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - in-order instruction buffer with dual-issue pairing
module issue_scheduler #(
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    issue_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic wr;
        logic rd_rs1;
        logic rd_rs2;
        logic ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ALUI:   begin d.wr = 1'b1; d.rd_rs1 = 1'b1; end
            OP_ALUR:   begin d.wr = 1'b1; d.rd_rs1 = 1'b1; d.rd_rs2 = 1'b1; end
            OP_LUI:    d.wr = 1'b1;
            OP_AUIPC:  d.wr = 1'b1;
            OP_JAL:    begin d.wr = 1'b1; d.ctrl = 1'b1; end
            OP_JALR:   begin d.wr = 1'b1; d.rd_rs1 = 1'b1; d.ctrl = 1'b1; end
            OP_BRANCH: begin d.rd_rs1 = 1'b1; d.rd_rs2 = 1'b1; d.ctrl = 1'b1; end
            default:   d = '0;
        endcase
        return d;
    endfunction

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    logic [AW-1:0] head1_ptr;
    logic [31:0]   head0, head1;
    dec_t          d0, d1;
    logic          raw, waw, pair_ok;
    logic [1:0]    valid;
    logic          push, pop;
    logic [1:0]    n_push, n_pop;

    assign head1_ptr = rd_ptr + AW'(1);
    assign head0     = instr_mem[rd_ptr];
    assign head1     = instr_mem[head1_ptr];
    assign d0        = decode(head0[6:0]);
    assign d1        = decode(head1[6:0]);

    // x0 as destination never creates a hazard, so rd0 != 0 gates both checks
    assign raw = d0.wr && (head0[11:7] != 5'd0) &&
                 ((d1.rd_rs1 && (head1[19:15] == head0[11:7])) ||
                  (d1.rd_rs2 && (head1[24:20] == head0[11:7])));
    assign waw = d0.wr && d1.wr && (head0[11:7] == head1[11:7]) && (head0[11:7] != 5'd0);
    assign pair_ok = !d0.ctrl && !raw && !waw;

    assign valid[0] = (count >= (AW+1)'(1));
    assign valid[1] = (count >= (AW+1)'(2)) && pair_ok;

    assign bus.fetch_ready_o  = (count <= READY_MAX);
    assign bus.issue_valid_o  = valid;
    assign bus.issue_instr0_o = head0;
    assign bus.issue_pc0_o    = pc_mem[rd_ptr];
    assign bus.issue_instr1_o = head1;
    assign bus.issue_pc1_o    = pc_mem[head1_ptr];

    assign push   = bus.fetch_valid_i && bus.fetch_ready_o && !flush_i;
    assign pop    = bus.issue_ready_i && valid[0] && !flush_i;
    assign n_push = push ? ({1'b0, bus.fetch_mask_i[0]} + {1'b0, bus.fetch_mask_i[1]}) : 2'd0;
    assign n_pop  = pop  ? ({1'b0, valid[0]} + {1'b0, valid[1]}) : 2'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_pop);
            wr_ptr <= wr_ptr + AW'(n_push);
            count  <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
        end
    end

    // Slot 1 lands right after slot 0, or at the write pointer when slot 0 is masked off
    always_ff @(posedge clk_i) begin
        if (push && bus.fetch_mask_i[0]) begin
            instr_mem[wr_ptr] <= bus.fetch_instr0_i;
            pc_mem[wr_ptr]    <= bus.fetch_pc_i;
        end
        if (push && bus.fetch_mask_i[1]) begin
            instr_mem[wr_ptr + AW'(bus.fetch_mask_i[0])] <= bus.fetch_instr1_i;
            pc_mem[wr_ptr + AW'(bus.fetch_mask_i[0])]    <= bus.fetch_pc_i + 32'd4;
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler against a queue reference model
module tb_issue_scheduler;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_ni;
    logic flush;

    issue_scheduler_if bus ();

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    int   pre_size;
    int   vectors;
    int   miscompares;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Register sets as 32-bit masks; bit 0 is dropped so x0 never forms a dependency
    function automatic logic [31:0] write_set(input logic [31:0] i);
        logic [31:0] s;
        s = 32'd0;
        if (i[6:0] inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67}) s[i[11:7]] = 1'b1;
        s[0] = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] read_set(input logic [31:0] i);
        logic [31:0] s;
        s = 32'd0;
        if (i[6:0] inside {7'h13, 7'h33, 7'h67, 7'h63}) s[i[19:15]] = 1'b1;
        if (i[6:0] inside {7'h33, 7'h63}) s[i[24:20]] = 1'b1;
        s[0] = 1'b0;
        return s;
    endfunction

    function automatic bit ref_pair(input logic [31:0] i0, input logic [31:0] i1);
        if (i0[6:0] inside {7'h6f, 7'h67, 7'h63}) return 1'b0;
        return (write_set(i0) & (read_set(i1) | write_set(i1))) == 32'd0;
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] beq(input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        ops[0] = 7'h13; ops[1] = 7'h33; ops[2] = 7'h37; ops[3] = 7'h17; ops[4] = 7'h6f;
        ops[5] = 7'h67; ops[6] = 7'h63; ops[7] = 7'h03; ops[8] = 7'h23;
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
    endfunction

    // Monitor: compare presented bundle with the model head, then retire what was accepted
    always @(negedge clk) begin
        logic [1:0] ev;
        if (rst_ni) begin
            pre_size = exp_q.size();
            ev[0] = pre_size >= 1;
            ev[1] = (pre_size >= 2) && ref_pair(exp_q[0].instr, exp_q[1].instr);
            chk("issue_valid", 64'(bus.issue_valid_o), 64'(ev));
            chk("fetch_ready", 64'(bus.fetch_ready_o), 64'(pre_size <= DEPTH - 2));
            if (ev[0]) begin
                chk("instr0", 64'(bus.issue_instr0_o), 64'(exp_q[0].instr));
                chk("pc0", 64'(bus.issue_pc0_o), 64'(exp_q[0].pc));
            end
            if (ev[1]) begin
                chk("instr1", 64'(bus.issue_instr1_o), 64'(exp_q[1].instr));
                chk("pc1", 64'(bus.issue_pc1_o), 64'(exp_q[1].pc));
            end
            if (flush) exp_q.delete();
            else if (bus.issue_ready_i && ev[0]) begin
                void'(exp_q.pop_front());
                if (ev[1]) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rst_ni) assert (dut.count <= DEPTH) else $error("FAIL count_bound: count %0d above %0d", dut.count, DEPTH);
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic cycle(input bit fv, input logic [1:0] m, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc, input bit rdy, input bit fl);
        bus.fetch_valid_i  = fv;
        bus.fetch_mask_i   = m;
        bus.fetch_instr0_i = i0;
        bus.fetch_instr1_i = i1;
        bus.fetch_pc_i     = pc;
        bus.issue_ready_i  = rdy;
        flush              = fl;
        @(negedge clk);
        #1;
        if (fv && !fl && pre_size <= DEPTH - 2) begin
            if (m[0]) exp_q.push_back('{instr: i0, pc: pc});
            if (m[1]) exp_q.push_back('{instr: i1, pc: pc + 32'd4});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic fill_pairs(input int n, input int base_rd, input logic [31:0] base_pc);
        for (int k = 0; k < n; k++)
            cycle(1'b1, 2'b11, addi(base_rd + 2*k, 0, k), addi(base_rd + 2*k + 1, 0, k + 1),
                  base_pc + 32'(8*k), 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        pre_size = 0;
        rst_ni = 1'b0;
        flush = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.fetch_mask_i = 2'b00;
        bus.fetch_instr0_i = 32'd0;
        bus.fetch_instr1_i = 32'd0;
        bus.fetch_pc_i = 32'd0;
        bus.issue_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.issue_valid_o), 64'd0);
        chk("reset_ready", 64'(bus.fetch_ready_o), 64'd1);
        rst_ni = 1'b1;

        // Basic pair
        cycle(1'b1, 2'b11, addi(1, 0, 5), addi(2, 0, 7), 32'h100, 1'b0, 1'b0);
        chk("pair_valid", 64'(bus.issue_valid_o), 64'h3);
        chk("pair_pc0", 64'(bus.issue_pc0_o), 64'h100);
        chk("pair_pc1", 64'(bus.issue_pc1_o), 64'h104);
        idle(1'b1);
        chk("pair_drained", 64'(bus.issue_valid_o), 64'h0);

        // RAW splits the pair
        cycle(1'b1, 2'b11, addi(3, 0, 1), add(4, 3, 3), 32'h140, 1'b0, 1'b0);
        chk("raw_valid", 64'(bus.issue_valid_o), 64'h1);
        idle(1'b1);
        chk("raw_second_valid", 64'(bus.issue_valid_o), 64'h1);
        chk("raw_second_instr", 64'(bus.issue_instr0_o), 64'(add(4, 3, 3)));
        idle(1'b1);

        // x0 destination pairs, control flow does not
        cycle(1'b1, 2'b11, addi(0, 0, 0), add(5, 0, 0), 32'h180, 1'b0, 1'b0);
        chk("x0_valid", 64'(bus.issue_valid_o), 64'h3);
        idle(1'b1);
        cycle(1'b1, 2'b11, beq(1, 2), addi(6, 0, 3), 32'h1c0, 1'b0, 1'b0);
        chk("branch_valid", 64'(bus.issue_valid_o), 64'h1);
        idle(1'b1);
        idle(1'b1);

        // Mask 10 carries only instruction 1 at pc+4
        cycle(1'b1, 2'b10, addi(7, 0, 1), addi(8, 0, 2), 32'h200, 1'b0, 1'b0);
        chk("mask10_valid", 64'(bus.issue_valid_o), 64'h1);
        chk("mask10_pc", 64'(bus.issue_pc0_o), 64'h204);
        chk("mask10_instr", 64'(bus.issue_instr0_o), 64'(addi(8, 0, 2)));
        idle(1'b1);

        // Fill to full across the wrap, blocked packet is ignored, then drain
        fill_pairs(4, 1, 32'h1000);
        chk("full_ready", 64'(bus.fetch_ready_o), 64'd0);
        cycle(1'b1, 2'b11, addi(20, 0, 0), addi(21, 0, 0), 32'h2000, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Seven entries already deasserts fetch_ready
        fill_pairs(3, 1, 32'h3000);
        cycle(1'b1, 2'b01, addi(9, 0, 9), addi(10, 0, 9), 32'h3018, 1'b0, 1'b0);
        chk("seven_ready", 64'(bus.fetch_ready_o), 64'd0);
        repeat (5) idle(1'b1);

        // Push two and pop two at count 4
        fill_pairs(2, 11, 32'h4000);
        cycle(1'b1, 2'b11, addi(15, 0, 1), addi(16, 0, 1), 32'h4010, 1'b1, 1'b0);
        chk("pushpop_ready", 64'(bus.fetch_ready_o), 64'd1);
        repeat (3) idle(1'b1);

        // Flush beats a coincident push and pop at count 5
        fill_pairs(2, 1, 32'h5000);
        cycle(1'b1, 2'b01, addi(9, 0, 1), 32'd0, 32'h5010, 1'b0, 1'b0);
        cycle(1'b1, 2'b11, addi(10, 0, 1), addi(11, 0, 1), 32'h5018, 1'b1, 1'b1);
        chk("flush_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("flush_ready", 64'(bus.fetch_ready_o), 64'd1);
        idle(1'b0);

        // Asynchronous reset mid-stream
        fill_pairs(2, 1, 32'h6000);
        idle(1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("midreset_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("midreset_ready", 64'(bus.fetch_ready_o), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) < 6), 2'($urandom), rand_instr(), rand_instr(),
                  {$urandom_range(0, 32'h3fff_ffff), 2'b00}, ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 39) == 0));
        end
        repeat (6) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
